// File: rtl/uart_fifo_ctrl.sv
// Buffers CPU bytes towards simpleuart and drains simpleuart's receive buffer into a FIFO.
// TX side drives the we/wait write handshake; RX side acknowledges each byte with one re pulse.
module uart_fifo_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_pop,
  output logic             rx_overrun,
  input  logic             ovr_clear,
  output logic [TX_AW:0]   tx_level,
  output logic [RX_AW:0]   rx_level,
  output logic             tx_idle,
  output logic             uart_we,
  output logic [7:0]       uart_di,
  input  logic             uart_wait,
  input  logic             uart_tdre,
  output logic             uart_re,
  input  logic [7:0]       uart_do,
  input  logic             uart_rx_valid
);

  localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};

  typedef enum logic {TX_IDLE, TX_REQ} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_DRAIN} rx_state_t;

  // ---------------- TX path ----------------
  logic [7:0]     tx_mem [0:(1<<TX_AW)-1];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW:0] tx_rptr_q, tx_rptr_d;
  tx_state_t      tx_state_q, tx_state_d;
  logic           uart_we_q, uart_we_d;
  logic [7:0]     uart_di_q, uart_di_d;
  logic           tx_push;
  logic           tx_pop;

  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign tx_ready = (tx_level != TX_DEPTH);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_idle  = (tx_level == '0) && (tx_state_q == TX_IDLE) && uart_tdre;
  assign uart_we  = uart_we_q;
  assign uart_di  = uart_di_q;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q[TX_AW-1:0]] <= tx_data;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    uart_we_d  = uart_we_q;
    uart_di_d  = uart_di_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        uart_we_d = 1'b0;
        if (tx_level != '0) begin
          uart_di_d  = tx_mem[tx_rptr_q[TX_AW-1:0]];
          uart_we_d  = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        // The byte is taken in the cycle wait is low; dropping we here guarantees a gap cycle.
        if (!uart_wait) begin
          tx_pop     = 1'b1;
          uart_we_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        uart_we_d  = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
    tx_wptr_d = tx_wptr_q + {{TX_AW{1'b0}}, tx_push};
    tx_rptr_d = tx_rptr_q + {{TX_AW{1'b0}}, tx_pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_state_q <= TX_IDLE;
      uart_we_q  <= 1'b0;
      uart_di_q  <= 8'h00;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_state_q <= tx_state_d;
      uart_we_q  <= uart_we_d;
      uart_di_q  <= uart_di_d;
    end
  end

  // ---------------- RX path ----------------
  logic [7:0]     rx_mem [0:(1<<RX_AW)-1];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
  logic [RX_AW:0] rx_rptr_q, rx_rptr_d;
  rx_state_t      rx_state_q, rx_state_d;
  logic           uart_re_q, uart_re_d;
  logic           rx_overrun_q, rx_overrun_d;
  logic           rx_capture;
  logic           rx_write;
  logic           rx_drop;
  logic           rx_pop_ok;

  assign rx_level   = rx_wptr_q - rx_rptr_q;
  assign rx_valid   = (rx_level != '0);
  assign rx_data    = rx_valid ? rx_mem[rx_rptr_q[RX_AW-1:0]] : 8'h00;
  assign rx_pop_ok  = rx_pop && rx_valid;
  assign rx_overrun = rx_overrun_q;
  assign uart_re    = uart_re_q;

  // Fullness uses the registered level, so a same-cycle pop cannot make room for the capture.
  assign rx_write = rx_capture && (rx_level != RX_DEPTH);
  assign rx_drop  = rx_capture && (rx_level == RX_DEPTH);

  always_ff @(posedge clk) begin
    if (rx_write) begin
      rx_mem[rx_wptr_q[RX_AW-1:0]] <= uart_do;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    uart_re_d  = 1'b0;
    rx_capture = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (uart_rx_valid) begin
          rx_capture = 1'b1;
          uart_re_d  = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        rx_state_d = RX_DRAIN;
      end
      RX_DRAIN: begin
        // Wait for the UART to retire its buffer so the same byte is not captured twice.
        if (!uart_rx_valid) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
    rx_wptr_d    = rx_wptr_q + {{RX_AW{1'b0}}, rx_write};
    rx_rptr_d    = rx_rptr_q + {{RX_AW{1'b0}}, rx_pop_ok};
    rx_overrun_d = (rx_overrun_q && !ovr_clear) || rx_drop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_state_q   <= RX_IDLE;
      uart_re_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      rx_state_q   <= rx_state_d;
      uart_re_q    <= uart_re_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl: TX handshake, RX ack, overrun, reset.
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       rx_overrun;
  logic       ovr_clear;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic       tx_idle;
  logic       uart_we;
  logic [7:0] uart_di;
  logic       uart_wait;
  logic       uart_tdre;
  logic       uart_re;
  logic [7:0] uart_do;
  logic       uart_rx_valid;

  int checks   = 0;
  int failures = 0;
  int re_cnt;
  int acc_cnt;
  int we_seen;
  logic [7:0] acc [0:31];

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.TX_AW(4), .RX_AW(4)) dut (
    .clk(clk), .resetn(resetn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .rx_overrun(rx_overrun), .ovr_clear(ovr_clear),
    .tx_level(tx_level), .rx_level(rx_level), .tx_idle(tx_idle),
    .uart_we(uart_we), .uart_di(uart_di), .uart_wait(uart_wait),
    .uart_tdre(uart_tdre), .uart_re(uart_re), .uart_do(uart_do),
    .uart_rx_valid(uart_rx_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART model: present a byte and retire it on the edge after uart_re is seen.
  task automatic rx_byte(input logic [7:0] b);
    uart_do       = b;
    uart_rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (uart_re) begin
        re_cnt++;
        uart_rx_valid = 1'b0;
      end
    end
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_pop = 1'b0; ovr_clear = 1'b0;
    uart_wait = 1'b0; uart_tdre = 1'b1; uart_do = 8'h00; uart_rx_valid = 1'b0;
    re_cnt = 0;
    #12;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_uart_we", uart_we, 0);
    chk("rst_uart_di", uart_di, 0);
    chk("rst_uart_re", uart_re, 0);
    chk("rst_tx_idle_tdre1", tx_idle, 1);
    uart_tdre = 1'b0; #1;
    chk("rst_tx_idle_tdre0", tx_idle, 0);
    uart_tdre = 1'b1;
    resetn = 1'b1;
    tick();

    // 1: single byte
    tx_valid = 1'b1; tx_data = 8'h55;
    tick();
    tx_valid = 1'b0;
    chk("t1_level_after_push", tx_level, 1);
    chk("t1_we_not_yet", uart_we, 0);
    chk("t1_idle_busy", tx_idle, 0);
    tick();
    chk("t1_we_high", uart_we, 1);
    chk("t1_di", uart_di, 8'h55);
    tick();
    chk("t1_we_dropped", uart_we, 0);
    chk("t1_level_zero", tx_level, 0);
    chk("t1_tx_idle", tx_idle, 1);

    // 2: fill with wait held, overflow push ignored
    uart_wait = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i);
      tick();
    end
    tx_valid = 1'b0;
    chk("t2_level_full", tx_level, 16);
    chk("t2_ready_low", tx_ready, 0);
    chk("t2_we_holding", uart_we, 1);
    chk("t2_di_first", uart_di, 8'h00);
    tx_valid = 1'b1; tx_data = 8'hAA;
    tick();
    tx_valid = 1'b0;
    chk("t2_level_after_17th", tx_level, 16);
    uart_wait = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 80 && acc_cnt < 20; c++) begin
      if (uart_we) begin
        acc[acc_cnt] = uart_di;
        acc_cnt++;
      end
      tick();
      if (tx_level == 0 && !uart_we) break;
    end
    chk("t2_accept_count", acc_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_byte%0d", i), acc[i], 8'(i));
    end
    chk("t2_level_drained", tx_level, 0);

    // 3: single RX byte
    re_cnt = 0;
    uart_do = 8'h41; uart_rx_valid = 1'b1;
    tick();
    chk("t3_rx_valid_latency", rx_valid, 1);
    chk("t3_re_high", uart_re, 1);
    re_cnt = 1; uart_rx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (uart_re) re_cnt++;
    end
    chk("t3_re_pulses", re_cnt, 1);
    chk("t3_rx_data", rx_data, 8'h41);
    chk("t3_rx_level", rx_level, 1);
    rx_pop = 1'b1;
    tick();
    chk("t3_rx_valid_after_pop", rx_valid, 0);
    chk("t3_rx_data_empty", rx_data, 8'h00);
    tick();
    rx_pop = 1'b0;
    chk("t3_pop_empty_ignored", rx_level, 0);

    // 4: overrun
    for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
    chk("t4_level_full", rx_level, 16);
    chk("t4_no_overrun_yet", rx_overrun, 0);
    re_cnt = 0;
    rx_byte(8'h7E);
    chk("t4_dropped_byte_acked", re_cnt, 1);
    chk("t4_overrun", rx_overrun, 1);
    chk("t4_level_still_full", rx_level, 16);
    chk("t4_head_unchanged", rx_data, 8'h80);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    chk("t4_overrun_cleared", rx_overrun, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_pop%0d", i), rx_data, 8'h80 + 8'(i));
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    chk("t4_rx_empty", rx_level, 0);

    // 5: simultaneous TX push/pop at level 3
    uart_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 8'hC0 + 8'(i);
      tick();
    end
    tx_valid = 1'b0;
    tick();
    chk("t5_tx_level3", tx_level, 3);
    chk("t5_we_req", uart_we, 1);
    tx_valid = 1'b1; tx_data = 8'hC3; uart_wait = 1'b0;
    tick();
    tx_valid = 1'b0; uart_wait = 1'b1;
    chk("t5_tx_level_kept", tx_level, 3);
    uart_wait = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (tx_level == 0 && !uart_we) break;
    end
    chk("t5_tx_drained", tx_level, 0);
    chk("t5_tx_idle", tx_idle, 1);

    // 5b: RX capture coincident with pop at level 5
    for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i));
    chk("t5_rx_level5", rx_level, 5);
    uart_do = 8'h15; uart_rx_valid = 1'b1; rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0; uart_rx_valid = 1'b0;
    chk("t5_rx_level_kept", rx_level, 5);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_rx_order%0d", i), rx_data, 8'h11 + 8'(i));
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    chk("t5_rx_empty", rx_level, 0);

    // 6: async reset mid TX_REQ
    rx_byte(8'h33);
    uart_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'hE0 + 8'(i);
      tick();
    end
    tx_valid = 1'b0;
    chk("t6_we_before_rst", uart_we, 1);
    chk("t6_tx_level4", tx_level, 4);
    chk("t6_rx_level1", rx_level, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_we_async", uart_we, 0);
    chk("t6_tx_level_async", tx_level, 0);
    chk("t6_rx_level_async", rx_level, 0);
    #3 resetn = 1'b1;
    uart_wait = 1'b0;
    we_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (uart_we) we_seen++;
    end
    chk("t6_no_we_after_release", we_seen, 0);
    chk("t6_tx_level_after", tx_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
